// File: rtl/ddp_pkt_arb_pkg.sv
// Shared beat-field positions and arbiter state encoding for the DDP packet arbiter.
package ddp_pkt_arb_pkg;

    localparam int SOP_BIT = 266;
    localparam int EOP_BIT = 265;
    localparam int BE_MSB  = 264;
    localparam int BE_LSB  = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ddp_arb_rr2.sv
// Two-requester round-robin picker; the lastGrant register lives in the parent.
module ddp_arb_rr2 (
    input  logic [1:0] req,
    input  logic       lastGrant,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                // On a tie, the source that did not win last time takes the sink.
                gnt = lastGrant ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/ddp_pkt_arb.sv
// Packet-atomic round-robin merge of two show-ahead DDP beat streams into one push sink.
module ddp_pkt_arb
    import ddp_pkt_arb_pkg::*;
#(
    parameter int BEAT_W = 267,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BEAT_W-1:0] src0DataOut,
    input  logic              src0DataValid,
    output logic              src0Pop,
    input  logic [BEAT_W-1:0] src1DataOut,
    input  logic              src1DataValid,
    output logic              src1Pop,
    output logic [BEAT_W-1:0] sinkDataIn,
    output logic              sinkPush,
    input  logic              sinkFull,
    output logic [CNT_W-1:0]  pktCount0,
    output logic [CNT_W-1:0]  pktCount1,
    output logic [CNT_W-1:0]  dropCount,
    output logic              busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last_grant;
    logic             w_last_grant_nxt;
    logic [CNT_W-1:0] r_pkt_cnt0;
    logic [CNT_W-1:0] r_pkt_cnt1;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [1:0]       w_req;
    logic [1:0]       w_orph;
    logic [1:0]       w_gnt;
    logic [1:0]       w_drop_pop;
    logic             w_done0;
    logic             w_done1;
    logic [1:0]       w_drop_inc;

    assign w_req[0]  = src0DataValid &  src0DataOut[SOP_BIT];
    assign w_req[1]  = src1DataValid &  src1DataOut[SOP_BIT];
    assign w_orph[0] = src0DataValid & ~src0DataOut[SOP_BIT];
    assign w_orph[1] = src1DataValid & ~src1DataOut[SOP_BIT];

    ddp_arb_rr2 u_rr2 (
        .req       (w_req),
        .lastGrant (r_last_grant),
        .enable    (r_state == IDLE),
        .gnt       (w_gnt)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        src0Pop          = 1'b0;
        src1Pop          = 1'b0;
        sinkPush         = 1'b0;
        w_drop_pop       = 2'b00;
        w_done0          = 1'b0;
        w_done1          = 1'b0;
        sinkDataIn       = (r_state == GRANT1) ? src1DataOut : src0DataOut;

        case (r_state)
            IDLE: begin
                // Orphans are flushed even on the cycle the other source is granted.
                w_drop_pop = w_orph;
                src0Pop    = w_orph[0];
                src1Pop    = w_orph[1];
                if (w_gnt[0]) begin
                    w_state_nxt      = GRANT0;
                    w_last_grant_nxt = 1'b0;
                end else if (w_gnt[1]) begin
                    w_state_nxt      = GRANT1;
                    w_last_grant_nxt = 1'b1;
                end
            end
            GRANT0: begin
                sinkPush = src0DataValid & ~sinkFull;
                src0Pop  = sinkPush;
                if (sinkPush && src0DataOut[EOP_BIT]) begin
                    w_done0     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GRANT1: begin
                sinkPush = src1DataValid & ~sinkFull;
                src1Pop  = sinkPush;
                if (sinkPush && src1DataOut[EOP_BIT]) begin
                    w_done1     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_drop_inc = {1'b0, w_drop_pop[0]} + {1'b0, w_drop_pop[1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_pkt_cnt0   <= '0;
            r_pkt_cnt1   <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_pkt_cnt0   <= r_pkt_cnt0 + CNT_W'(w_done0);
            r_pkt_cnt1   <= r_pkt_cnt1 + CNT_W'(w_done1);
            r_drop_cnt   <= r_drop_cnt + CNT_W'(w_drop_inc);
        end
    end

    assign pktCount0 = r_pkt_cnt0;
    assign pktCount1 = r_pkt_cnt1;
    assign dropCount = r_drop_cnt;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ddp_pkt_arb.sv
// Directed bench for ddp_pkt_arb: queue-backed show-ahead sources, push log, hand-computed expectations.
module tb_ddp_pkt_arb;

    localparam int BEAT_W = 267;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [BEAT_W-1:0] src0DataOut;
    logic              src0DataValid;
    logic              src0Pop;
    logic [BEAT_W-1:0] src1DataOut;
    logic              src1DataValid;
    logic              src1Pop;
    logic [BEAT_W-1:0] sinkDataIn;
    logic              sinkPush;
    logic              sinkFull;
    logic [CNT_W-1:0]  pktCount0;
    logic [CNT_W-1:0]  pktCount1;
    logic [CNT_W-1:0]  dropCount;
    logic              busy;

    ddp_pkt_arb #(.BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .src0DataOut   (src0DataOut),
        .src0DataValid (src0DataValid),
        .src0Pop       (src0Pop),
        .src1DataOut   (src1DataOut),
        .src1DataValid (src1DataValid),
        .src1Pop       (src1Pop),
        .sinkDataIn    (sinkDataIn),
        .sinkPush      (sinkPush),
        .sinkFull      (sinkFull),
        .pktCount0     (pktCount0),
        .pktCount1     (pktCount1),
        .dropCount     (dropCount),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    logic [BEAT_W-1:0] q0[$];
    logic [BEAT_W-1:0] q1[$];
    logic [BEAT_W-1:0] lg[$];
    logic [BEAT_W-1:0] exp_lg[$];
    bit                hist[$];
    bit                en0, en1, full_req, rst_req;
    bit                last_push, last_busy, last_pop0, last_pop1;
    int                npop0, npop1, npush;
    int                n_checks = 0;
    int                n_fail   = 0;

    task automatic chk(input string tag, input logic [BEAT_W-1:0] obs, input logic [BEAT_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] mk(input bit sop, input bit eop, input int id);
        logic [31:0] v;
        v  = id;
        mk = {sop, eop, 9'h1FF, 224'd0, v};
    endfunction

    // Drive at negedge, sample combinational outputs 1ns later, advance queues on observed pops.
    task automatic cyc();
        @(negedge clock);
        reset         = rst_req;
        sinkFull      = full_req;
        src0DataValid = en0 && (q0.size() > 0);
        src0DataOut   = (q0.size() > 0) ? q0[0] : '0;
        src1DataValid = en1 && (q1.size() > 0);
        src1DataOut   = (q1.size() > 0) ? q1[0] : '0;
        #1;
        last_push = sinkPush;
        last_busy = busy;
        last_pop0 = src0Pop;
        last_pop1 = src1Pop;
        hist.push_back(sinkPush);
        if (sinkPush) begin
            lg.push_back(sinkDataIn);
            npush++;
        end
        if (src0Pop) begin
            npop0++;
            if (q0.size() > 0) void'(q0.pop_front());
        end
        if (src1Pop) begin
            npop1++;
            if (q1.size() > 0) void'(q1.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clr();
        lg.delete(); exp_lg.delete(); hist.delete();
        npop0 = 0; npop1 = 0; npush = 0;
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        en0 = 1; en1 = 1; full_req = 0;
        rst_req = 1;
        run(2);
        rst_req = 0;
        clr();
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, BEAT_W'(lg.size()), BEAT_W'(exp_lg.size()));
        for (int i = 0; i < exp_lg.size(); i++) begin
            if (i < lg.size()) chk($sformatf("%s_beat%0d", tag, i), lg[i], exp_lg[i]);
        end
    endtask

    initial begin
        reset = 1; sinkFull = 0;
        src0DataOut = '0; src0DataValid = 0; src1DataOut = '0; src1DataValid = 0;
        en0 = 1; en1 = 1; full_req = 0; rst_req = 1;

        // Reset state
        do_reset();
        run(1);
        chk("rst_push", BEAT_W'(last_push), '0);
        chk("rst_busy", BEAT_W'(last_busy), '0);
        chk("rst_pop0", BEAT_W'(last_pop0), '0);
        chk("rst_pop1", BEAT_W'(last_pop1), '0);
        chk("rst_cnt0", BEAT_W'(pktCount0), '0);
        chk("rst_cnt1", BEAT_W'(pktCount1), '0);
        chk("rst_drop", BEAT_W'(dropCount), '0);

        // Single source, 3-beat packet
        do_reset();
        q0.push_back(mk(1, 0, 'h001)); q0.push_back(mk(0, 0, 'h002)); q0.push_back(mk(0, 1, 'h003));
        exp_lg = q0;
        run(5);
        chk("single_c0", BEAT_W'(hist[0]), '0);
        chk("single_c1", BEAT_W'(hist[1]), 1);
        chk("single_c2", BEAT_W'(hist[2]), 1);
        chk("single_c3", BEAT_W'(hist[3]), 1);
        chk("single_c4", BEAT_W'(hist[4]), '0);
        check_log("single");
        chk("single_cnt0", BEAT_W'(pktCount0), 1);
        chk("single_busy", BEAT_W'(busy), '0);

        // Tie round-robin: order 0,1,0,1
        do_reset();
        q0.push_back(mk(1, 1, 'h010)); q0.push_back(mk(1, 1, 'h011));
        q1.push_back(mk(1, 1, 'h110)); q1.push_back(mk(1, 1, 'h111));
        exp_lg.push_back(mk(1, 1, 'h010)); exp_lg.push_back(mk(1, 1, 'h110));
        exp_lg.push_back(mk(1, 1, 'h011)); exp_lg.push_back(mk(1, 1, 'h111));
        run(9);
        check_log("tie");
        chk("tie_cnt0", BEAT_W'(pktCount0), 2);
        chk("tie_cnt1", BEAT_W'(pktCount1), 2);

        // Atomicity: src1 requests while src0 is mid-packet
        do_reset();
        en1 = 0;
        for (int i = 0; i < 4; i++) q0.push_back(mk(i == 0, i == 3, 'h020 + i));
        q1.push_back(mk(1, 1, 'h120));
        exp_lg = q0;
        exp_lg.push_back(mk(1, 1, 'h120));
        run(2);
        en1 = 1;
        run(8);
        check_log("atom");
        chk("atom_cnt0", BEAT_W'(pktCount0), 1);
        chk("atom_cnt1", BEAT_W'(pktCount1), 1);

        // Backpressure for 5 cycles mid-packet
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back(mk(i == 0, i == 3, 'h030 + i));
        exp_lg = q0;
        run(2);
        npop0 = 0; npush = 0;
        full_req = 1;
        run(5);
        chk("bp_push", BEAT_W'(npush), '0);
        chk("bp_pop0", BEAT_W'(npop0), '0);
        chk("bp_busy", BEAT_W'(busy), 1);
        full_req = 0;
        run(5);
        check_log("bp");
        chk("bp_cnt0", BEAT_W'(pktCount0), 1);

        // Orphans on src0 while src1 sends a 1-beat packet
        do_reset();
        q0.push_back(mk(0, 0, 'h040)); q0.push_back(mk(0, 1, 'h041));
        q1.push_back(mk(1, 1, 'h140));
        exp_lg.push_back(mk(1, 1, 'h140));
        run(5);
        check_log("orph");
        chk("orph_pop0", BEAT_W'(npop0), 2);
        chk("orph_drop", BEAT_W'(dropCount), 2);
        chk("orph_cnt1", BEAT_W'(pktCount1), 1);
        chk("orph_cnt0", BEAT_W'(pktCount0), '0);

        // Reset on beat 2 of a 4-beat packet
        do_reset();
        for (int i = 0; i < 4; i++) q0.push_back(mk(i == 0, i == 3, 'h050 + i));
        run(2);
        rst_req = 1;
        run(1);
        rst_req = 0;
        chk("rmid_q0_left", BEAT_W'(q0.size()), 2);
        run(1);
        chk("rmid_push", BEAT_W'(last_push), '0);
        chk("rmid_busy", BEAT_W'(last_busy), '0);
        chk("rmid_cnt0", BEAT_W'(pktCount0), '0);
        chk("rmid_drop0", BEAT_W'(dropCount), 1);
        run(3);
        chk("rmid_drop", BEAT_W'(dropCount), 2);
        chk("rmid_q0_empty", BEAT_W'(q0.size()), '0);
        chk("rmid_cnt0_end", BEAT_W'(pktCount0), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddp_pkt_arb.md
# ddp_pkt_arb

Packet-atomic two-input arbiter that merges two DDP beat streams into one downstream push interface. Both inputs and the output use the 267-bit beat format {sop, eop, byteenable[8:0], pkt[255:0]}. Source 0 is the cut/pad FIFO read side. Source 1 is a locally generated stream, such as an ACK/REQ responder. Sharing rotates round-robin between packets, and a granted packet is never interleaved. Beats with no preceding sop are discarded and counted.

## Interface
Parameters:
- BEAT_W, 267, beat width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- src0DataOut  in  BEAT_W  source 0 head beat (show-ahead).
- src0DataValid  in  1  source 0 head beat present.
- src0Pop  out  1  consumes source 0 head this cycle.
- src1DataOut  in  BEAT_W  source 1 head beat.
- src1DataValid  in  1  source 1 head beat present.
- src1Pop  out  1  consumes source 1 head this cycle.
- sinkDataIn  out  BEAT_W  beat to downstream FIFO.
- sinkPush  out  1  write strobe.
- sinkFull  in  1  downstream FIFO full.
- pktCount0, pktCount1  out  CNT_W  packets forwarded per source; eop beats counted.
- dropCount  out  CNT_W  orphan beats discarded, both sources summed.
- busy  out  1  state is not IDLE.

## Operation
- sop = beat[266], eop = beat[265].
- States:
  - IDLE: no packet in progress.
  - GRANT0: source 0 owns the sink.
  - GRANT1: source 1 owns the sink.
- Request: reqN = srcNDataValid & srcNDataOut[266], evaluated in IDLE only.
- Orphan: orphN = srcNDataValid & ~srcNDataOut[266], evaluated in IDLE only.
  - In IDLE, each source with orphN asserts srcNPop that cycle.
  - dropCount += number of orphans popped that cycle (0, 1 or 2), wrapping.
- Arbitration in IDLE:
  - Only req0 → GRANT0. Only req1 → GRANT1.
  - Both asserted → the source other than lastGrant wins, then lastGrant updates.
  - lastGrant resets to 1, so source 0 wins the first tie.
  - Neither asserted → stay in IDLE.
  - No pop and no push occur on the grant cycle.
- GRANTn transfer:
  - fire = srcNDataValid & ~sinkFull.
  - sinkPush = fire; srcNPop = fire; sinkDataIn = srcNDataOut, forwarded unmodified.
  - Non-granted source pop = 0.
  - On fire with eop = 1: pktCountN += 1 (wrapping) and go to IDLE.
- sop inside a grant, after the first beat: forwarded as-is. No re-arbitration and no error; upstream guarantees framing.
- sinkDataIn is don't-care when sinkPush = 0. It is driven from the granted source; IDLE selects source 0.

## Timing
- Reset values:
  - state = IDLE, lastGrant = 1.
  - All counters = 0.
  - srcNPop = 0, sinkPush = 0, busy = 0.
- srcNPop and sinkPush are combinational from the registered state and current inputs. Same-cycle consume is the show-ahead FIFO contract.
- Latency:
  - One grant cycle in IDLE, then one beat per cycle while valid and not full.
  - A single-beat packet occupies 2 cycles.
  - Maximum throughput for an N-beat packet is N/(N+1).
- Backpressure: sinkFull = 1 stalls the transfer with no pop. State is held indefinitely.
- Valid gap mid-packet: state held, grant kept, no timeout.
- Orphan discard and grant in the same IDLE cycle: allowed. Example: source 0 has an orphan while source 1 requests. Source 0 is popped and source 1 is granted.
- Counter wrap: all-ones + 1 = 0. No saturation.
- Reset mid-packet: returns to IDLE immediately. The remainder of the packet then arrives as orphans and is dropped and counted.

## Structure
- Shared package/header:
  - Beat field positions (SOP_BIT = 266, EOP_BIT = 265, BE_MSB/LSB = 264/256).
  - State encodings IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2.
- Sub-module ddp_arb_rr2: two-requester round-robin picker.
  - Inputs: req[1:0], lastGrant, enable.
  - Outputs: gnt[1:0].
  - Pure combinational, with the lastGrant register held in the parent.
- Counters are inline.

## Test plan
- Single source:
  - Stimulus: src0 sends a 3-beat packet (sop / mid / eop), sinkFull = 0.
  - Response: 1 grant cycle, then sinkPush on 3 consecutive cycles with data identical; pktCount0 = 1; busy deasserts after the eop.
- Tie round-robin:
  - Stimulus: both sources hold 1-beat packets continuously for 4 packets.
  - Response: grant order 0, 1, 0, 1; pktCount0 = pktCount1 = 2.
- Atomicity:
  - Stimulus: src1 raises a sop request while src0 is mid 4-beat packet.
  - Response: no src1 beat appears until src0's eop is pushed.
- Backpressure:
  - Stimulus: sinkFull = 1 for 5 cycles in the middle of a packet.
  - Response: no pops and no pushes during those cycles; the packet resumes intact; no beat is lost or duplicated.
- Orphans:
  - Stimulus: src0 presents 2 non-sop beats in IDLE while src1 sends a 1-beat packet.
  - Response: both orphans are popped, dropCount = 2, and the src1 packet is forwarded.
- Reset mid-packet:
  - Stimulus: assert reset on beat 2 of a 4-beat packet.
  - Response: all outputs and counters are 0 the next cycle. The remaining 2 beats are dropped, so dropCount = 2.
